// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch sequencer: requests one word at the
// current PC, holds it for execution, then advances or halts on a fault.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] next_ins_addr,
    output logic [31:0] ins_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    output logic [31:0] ins,
    output logic        ins_valid,
    output logic [31:0] inst_count,
    output logic [1:0]  err_code
);

    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   wait_cnt;
    logic [31:0]     pc_q;
    logic [31:0]     ins_q;
    logic [31:0]     count_q;
    logic [1:0]      err_q;
    logic            timeout_hit;
    logic            next_aligned;

    // Handshake: a fetch completes on the rising edge where imem_req and
    // imem_ack are both high; imem_addr is held constant until then.
    assign timeout_hit  = (wait_cnt == CW'(TIMEOUT - 1));
    assign next_aligned = (next_ins_addr[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  state_next = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    state_next = EXEC;
                end else if (timeout_hit) begin
                    state_next = HALT;
                end
            end
            EXEC: begin
                if (!stall) begin
                    state_next = next_aligned ? FETCH : HALT;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        ins_valid = 1'b0;
        case (state)
            FETCH:   imem_req  = 1'b1;
            EXEC:    ins_valid = 1'b1;
            default: begin
                imem_req  = 1'b0;
                ins_valid = 1'b0;
            end
        endcase
    end

    // Datapath registers only move in FETCH and EXEC; HALT freezes everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q     <= {RESET_PC[31:2], 2'b00};
            ins_q    <= 32'h0;
            count_q  <= 32'h0;
            err_q    <= ERR_NONE;
            wait_cnt <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        ins_q    <= imem_rdata;
                        wait_cnt <= '0;
                    end else if (timeout_hit) begin
                        err_q <= ERR_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        count_q <= count_q + 32'd1;
                        if (next_aligned) begin
                            pc_q <= next_ins_addr;
                        end else begin
                            err_q <= ERR_ALIGN;
                        end
                    end
                end
                default: begin
                    pc_q <= pc_q;
                end
            endcase
        end
    end

    assign ins_addr   = pc_q;
    assign imem_addr  = pc_q;
    assign ins        = ins_q;
    assign inst_count = count_q;
    assign err_code   = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: reset, fetch latency, stall, redirect,
// misalignment and timeout faults, reset during fetch, and counter wrap.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] next_ins_addr;
    logic [31:0] ins_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic [31:0] ins;
    logic        ins_valid;
    logic [31:0] inst_count;
    logic [1:0]  err_code;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_unit #(
        .RESET_PC (32'h0000_3000),
        .TIMEOUT  (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .next_ins_addr (next_ins_addr),
        .ins_addr      (ins_addr),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .ins           (ins),
        .ins_valid     (ins_valid),
        .inst_count    (inst_count),
        .err_code      (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle so outputs are sampled away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        next_ins_addr = 32'h0000_3004;
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0;
        stall         = 1'b0;
        step();
        step();
        check("rst_req",   {31'b0, imem_req},   32'd0);
        check("rst_valid", {31'b0, ins_valid},  32'd0);
        check("rst_addr",  ins_addr,            32'h0000_3000);
        check("rst_ins",   ins,                 32'h0);
        check("rst_count", inst_count,          32'h0);
        check("rst_err",   {30'b0, err_code},   32'h0);

        // Minimum-latency fetch: ack on the first FETCH cycle.
        rst_n = 1'b1;
        step();
        check("t1_req",  {31'b0, imem_req}, 32'd1);
        check("t1_addr", imem_addr,         32'h0000_3000);
        imem_ack   = 1'b1;
        imem_rdata = 32'h2008_0005;
        step();
        check("t1_valid",    {31'b0, ins_valid}, 32'd1);
        check("t1_ins",      ins,                32'h2008_0005);
        check("t1_req_exec", {31'b0, imem_req},  32'd0);
        imem_ack = 1'b0;
        step();
        check("t1_valid_drop", {31'b0, ins_valid}, 32'd0);
        check("t1_next_addr",  imem_addr,          32'h0000_3004);
        check("t1_count",      inst_count,         32'd1);

        // Ack delayed by 3 cycles: request held 4 cycles, address stable.
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_req_hold",  {31'b0, imem_req}, 32'd1);
            check("t2_addr_hold", imem_addr,         32'h0000_3004);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_0001;
        step();
        check("t2_valid", {31'b0, ins_valid}, 32'd1);
        check("t2_ins",   ins,                32'hDEAD_0001);

        // Stall for 5 cycles with a stray ack that must not touch ins.
        stall         = 1'b1;
        imem_rdata    = 32'hBAD0_BAD0;
        next_ins_addr = 32'h0000_3008;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_valid", {31'b0, ins_valid}, 32'd1);
            check("t3_ins",   ins,                32'hDEAD_0001);
            check("t3_addr",  ins_addr,           32'h0000_3004);
            check("t3_count", inst_count,         32'd1);
        end
        stall    = 1'b0;
        imem_ack = 1'b0;
        step();
        check("t3_release_addr",  imem_addr,  32'h0000_3008);
        check("t3_release_count", inst_count, 32'd2);
        step();
        check("t3_advance_once", imem_addr, 32'h0000_3008);

        // Branch redirect, then a misaligned target.
        imem_ack      = 1'b1;
        imem_rdata    = 32'h0000_1111;
        next_ins_addr = 32'h0000_3010;
        step();
        imem_ack = 1'b0;
        step();
        check("t4_redirect", imem_addr,  32'h0000_3010);
        check("t4_count",    inst_count, 32'd3);
        imem_ack      = 1'b1;
        imem_rdata    = 32'h0000_2222;
        step();
        next_ins_addr = 32'h0000_3012;
        imem_ack      = 1'b0;
        step();
        check("t4_err_align", {30'b0, err_code}, 32'h1);
        check("t4_halt_req",  {31'b0, imem_req},  32'd0);
        check("t4_halt_val",  {31'b0, ins_valid}, 32'd0);
        check("t4_addr_kept", ins_addr,           32'h0000_3010);
        check("t4_count",     inst_count,         32'd4);
        imem_ack   = 1'b1;
        imem_rdata = 32'hFFFF_0000;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_halt_ins",  ins,                32'h0000_2222);
            check("t4_halt_req2", {31'b0, imem_req},  32'd0);
            check("t4_halt_err",  {30'b0, err_code},  32'h1);
        end

        // Reset out of HALT, then time out after 4 FETCH cycles.
        imem_ack = 1'b0;
        rst_n    = 1'b0;
        step();
        check("t5_rst_err",  {30'b0, err_code}, 32'h0);
        check("t5_rst_addr", ins_addr,          32'h0000_3000);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_wait_req", {31'b0, imem_req}, 32'd1);
        end
        step();
        check("t5_err_timeout", {30'b0, err_code}, 32'h2);
        check("t5_halt_req",    {31'b0, imem_req}, 32'd0);
        rst_n = 1'b0;
        step();
        check("t5_rst2_err",  {30'b0, err_code}, 32'h0);
        check("t5_rst2_addr", ins_addr,          32'h0000_3000);

        // Reset coincident with ack mid-FETCH; the late ack is ignored.
        rst_n = 1'b1;
        step();
        check("t6_in_fetch", {31'b0, imem_req}, 32'd1);
        rst_n      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h5555_AAAA;
        step();
        check("t6_req_drop", {31'b0, imem_req},  32'd0);
        check("t6_ins_zero", ins,                32'h0);
        check("t6_no_valid", {31'b0, ins_valid}, 32'd0);
        rst_n = 1'b1;
        step();
        check("t6_idle_ins", ins,               32'h0);
        check("t6_refetch",  {31'b0, imem_req}, 32'd1);

        // Counter wrap: preload all-ones while stalled, then retire once.
        imem_rdata = 32'h0000_7777;
        step();
        check("t7_exec", {31'b0, ins_valid}, 32'd1);
        stall         = 1'b1;
        imem_ack      = 1'b0;
        next_ins_addr = 32'h0000_3004;
        #2;
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        step();
        check("t7_preload", inst_count, 32'hFFFF_FFFF);
        stall = 1'b0;
        step();
        check("t7_wrap",     inst_count,         32'h0);
        check("t7_wrap_err", {30'b0, err_code},  32'h0);
        check("t7_wrap_pc",  imem_addr,          32'h0000_3004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
